// File: rtl/encoder_16_4_debounced_pkg.sv
// ----------------------------------------------------------------------------
// encoder_pkg
// Shared definitions for the debounced 16-to-4 key encoder:
//   state_t      - debounce FSM states (ST_STABLE = 0, ST_SETTLING = 1)
//   prio_enc16   - 16 -> 4 priority encode, highest set bit wins, 0 if none
//   multi_hot16  - true when more than one bit of the vector is set
// ----------------------------------------------------------------------------
package encoder_pkg;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    function automatic logic [3:0] prio_enc16(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        // Ascending scan so the last (highest) set bit overwrites lower ones.
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic multi_hot16(input logic [15:0] v);
        // Clearing the lowest set bit leaves something only if 2+ bits were set.
        return (v & (v - 16'd1)) != 16'd0;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for asynchronous board inputs, one chain per bit.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset, clears both stages to 0
//   d      in   WIDTH raw asynchronous inputs
//   q      out  WIDTH synchronized outputs (two clk edges behind d)
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            q     <= '0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end

endmodule

// File: rtl/encoder_16_4_debounced.sv
// ----------------------------------------------------------------------------
// encoder_16_4_debounced
// Registered 16-to-4 priority encoder for the waterfall board keys. The raw
// key vector is synchronized, debounced as a whole, then encoded; Y feeds
// the 4-16 LED decoder directly.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   D          in   16 raw asynchronous key inputs, active-high
//   Y          out  index of the highest set debounced key, 0 when none
//   valid      out  at least one debounced key is set
//   multi      out  more than one debounced key is set
//   new_pulse  out  one-cycle pulse when a new key code becomes valid
// ----------------------------------------------------------------------------
module encoder_16_4_debounced
    import encoder_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int CNT_W      = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] D,
    output logic [3:0]  Y,
    output logic        valid,
    output logic        multi,
    output logic        new_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [15:0]      sync2;
    logic [15:0]      cand;
    logic [15:0]      stable_vec;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    logic [3:0]       next_y;
    logic             next_valid;

    // ---- synchronizer stage ----
    sync_2ff #(
        .WIDTH(16)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (D),
        .q     (sync2)
    );

    // ---- debounce stage ----
    // One counter serves the whole vector: any bit changing restarts the
    // count, so a chord is only accepted once every key has settled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_STABLE;
            cand       <= '0;
            stable_vec <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_STABLE: begin
                    if (sync2 != stable_vec) begin
                        cand  <= sync2;
                        cnt   <= '0;
                        state <= ST_SETTLING;
                    end
                end
                ST_SETTLING: begin
                    if (sync2 != cand) begin
                        cand <= sync2;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // May commit the old value after a bounce; the
                        // encode stage then sees no change.
                        stable_vec <= cand;
                        state      <= ST_STABLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // ---- encode stage ----
    assign next_y     = prio_enc16(stable_vec);
    assign next_valid = |stable_vec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Y         <= 4'h0;
            valid     <= 1'b0;
            multi     <= 1'b0;
            new_pulse <= 1'b0;
        end else begin
            Y         <= next_y;
            valid     <= next_valid;
            multi     <= multi_hot16(stable_vec);
            // Only a change of the winning index is news; lower keys joining
            // or leaving under the same top key are not.
            new_pulse <= next_valid && (!valid || (next_y != Y));
        end
    end

endmodule

// File: tb/tb_encoder_16_4_debounced.sv
module tb_encoder_16_4_debounced;

    localparam int DEB = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] D     = 16'h0000;
    logic [3:0]  Y;
    logic        valid;
    logic        multi;
    logic        new_pulse;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    encoder_16_4_debounced #(
        .DEB_CYCLES(DEB),
        .CNT_W     (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D         (D),
        .Y         (Y),
        .valid     (valid),
        .multi     (multi),
        .new_pulse (new_pulse)
    );

    // Reference model: the FSM observes the key vector two edges late; a
    // value is accepted at the edge where the observed vector has been
    // identical for DEB+1 consecutive edges right after a change. Outputs
    // reflect the accepted vector one edge later.
    logic [15:0] m_pipe0, m_pipe1;
    logic [15:0] m_hist[$];
    logic [15:0] m_stable;
    logic [3:0]  m_y;
    logic        m_valid, m_multi, m_pulse;

    wire [6:0] got = {Y, valid, multi, new_pulse};

    function automatic logic [6:0] mexp();
        return {m_y, m_valid, m_multi, m_pulse};
    endfunction

    task automatic tick();
        logic [15:0] d_s;
        logic        r_s;
        logic [15:0] s;
        logic        commit;
        logic        nv;
        logic [3:0]  ny;
        d_s = D;
        r_s = rst_n;
        @(posedge clk);
        if (!r_s) begin
            m_pipe0 = '0;
            m_pipe1 = '0;
            m_hist  = {};
            for (int i = 0; i < DEB + 2; i++) m_hist.push_back(16'h0000);
            m_stable = '0;
            m_y = '0; m_valid = 1'b0; m_multi = 1'b0; m_pulse = 1'b0;
        end else begin
            s       = m_pipe1;
            m_pipe1 = m_pipe0;
            m_pipe0 = d_s;
            m_hist.push_back(s);
            void'(m_hist.pop_front());
            commit = (m_hist[0] != m_hist[1]);
            for (int i = 2; i <= DEB + 1; i++)
                if (m_hist[i] != m_hist[1]) commit = 1'b0;
            nv = (m_stable != 16'h0000);
            ny = nv ? 4'($clog2(32'(m_stable) + 1) - 1) : 4'd0;
            m_pulse = nv && (!m_valid || ny != m_y);
            m_multi = ($countones(m_stable) > 1);
            m_y     = ny;
            m_valid = nv;
            if (commit) m_stable = m_hist[DEB + 1];
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        D     = 16'hFFFF;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if (got !== 7'b0) begin
                failures++;
                $display("FAIL reset cyc=%0d Y,valid,multi,pulse got=%b exp=%b", e, got, 7'b0);
            end
        end
        rst_n = 1'b1;
        D     = 16'h0000;
        for (int e = 0; e < 4; e++) begin
            tick();
            checks++;
            if (got !== 7'b0) begin
                failures++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", e, got, 7'b0);
            end
        end
    endtask

    task automatic test_single_key();
        D = 16'h0020;
        for (int e = 0; e <= 9; e++) begin
            tick();
            checks++;
            if (got !== mexp()) begin
                failures++;
                $display("FAIL single_model edge=%0d got=%b exp=%b", e, got, mexp());
            end
            checks++;
            if (e <= 6 && got !== 7'b0) begin
                failures++;
                $display("FAIL single_early edge=%0d got=%b exp=%b", e, got, 7'b0);
            end else if (e == 7 && got !== {4'd5, 1'b1, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL single_edge7 got=%b exp=%b", got, {4'd5, 3'b101});
            end else if (e >= 8 && got !== {4'd5, 1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL single_hold edge=%0d got=%b exp=%b", e, got, {4'd5, 3'b100});
            end
        end
        D = 16'h0000;
        for (int e = 0; e < 12; e++) begin
            tick();
            checks++;
            if (got !== mexp() || new_pulse !== 1'b0) begin
                failures++;
                $display("FAIL single_release edge=%0d got=%b exp=%b", e, got, mexp());
            end
        end
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL single_idle got=%b exp=%b", got, 7'b0);
        end
    endtask

    task automatic test_bounce();
        for (int e = 0; e < 24; e++) begin
            D = (e < 12 && ((e / 2) % 2 == 0)) ? 16'h0020 : 16'h0000;
            tick();
            checks++;
            if (got !== mexp() || got !== 7'b0) begin
                failures++;
                $display("FAIL bounce edge=%0d got=%b exp=%b", e, got, 7'b0);
            end
        end
    endtask

    task automatic test_multi();
        int pulses;
        pulses = 0;
        D = 16'h8001;
        for (int e = 0; e < 10; e++) begin
            tick();
            pulses += int'(new_pulse);
            checks++;
            if (got !== mexp()) begin
                failures++;
                $display("FAIL multi_model edge=%0d got=%b exp=%b", e, got, mexp());
            end
            checks++;
            if (e == 7 && got !== {4'd15, 3'b111}) begin
                failures++;
                $display("FAIL multi_edge7 got=%b exp=%b", got, {4'd15, 3'b111});
            end
        end
        D = 16'h8000;
        for (int e = 0; e < 10; e++) begin
            tick();
            pulses += int'(new_pulse);
            checks++;
            if (got !== mexp()) begin
                failures++;
                $display("FAIL multi_drop edge=%0d got=%b exp=%b", e, got, mexp());
            end
        end
        checks++;
        if (got !== {4'd15, 3'b100}) begin
            failures++;
            $display("FAIL multi_single got=%b exp=%b", got, {4'd15, 3'b100});
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL multi_pulses got=%0d exp=1", pulses);
        end
        D = 16'h0000;
        for (int e = 0; e < 12; e++) begin
            tick();
            checks++;
            if (got !== mexp() || new_pulse !== 1'b0) begin
                failures++;
                $display("FAIL multi_release edge=%0d got=%b exp=%b", e, got, mexp());
            end
        end
    endtask

    task automatic test_change();
        D = 16'h0020;
        for (int e = 0; e < 10; e++) begin
            tick();
            checks++;
            if (got !== mexp()) begin
                failures++;
                $display("FAIL change_first edge=%0d got=%b exp=%b", e, got, mexp());
            end
        end
        D = 16'h0100;
        for (int e = 0; e < 10; e++) begin
            tick();
            checks++;
            if (got !== mexp()) begin
                failures++;
                $display("FAIL change_model edge=%0d got=%b exp=%b", e, got, mexp());
            end
            checks++;
            if (e == 7 && got !== {4'd8, 3'b101}) begin
                failures++;
                $display("FAIL change_edge7 got=%b exp=%b", got, {4'd8, 3'b101});
            end
        end
        D = 16'h0000;
        for (int e = 0; e < 12; e++) begin
            tick();
            checks++;
            if (got !== mexp() || new_pulse !== 1'b0) begin
                failures++;
                $display("FAIL change_release edge=%0d got=%b exp=%b", e, got, mexp());
            end
        end
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL change_idle got=%b exp=%b", got, 7'b0);
        end
    endtask

    task automatic test_reset_mid();
        D = 16'h0004;
        for (int e = 0; e <= 15; e++) begin
            rst_n = (e == 4 || e == 5) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (got !== mexp()) begin
                failures++;
                $display("FAIL rstmid_model edge=%0d got=%b exp=%b", e, got, mexp());
            end
            checks++;
            if (e < 13 && valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_early edge=%0d valid got=%b exp=0", e, valid);
            end else if (e == 13 && got !== {4'd2, 3'b101}) begin
                failures++;
                $display("FAIL rstmid_edge13 got=%b exp=%b", got, {4'd2, 3'b101});
            end
        end
        rst_n = 1'b1;
        D     = 16'h0000;
        for (int e = 0; e < 12; e++) begin
            tick();
            checks++;
            if (got !== mexp()) begin
                failures++;
                $display("FAIL rstmid_release edge=%0d got=%b exp=%b", e, got, mexp());
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] nd;
        int          hold;
        logic        prev_pulse;
        prev_pulse = 1'b0;
        hold       = 0;
        nd         = 16'h0000;
        for (int e = 0; e < 600; e++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 4))
                    0:       nd = 16'h0000;
                    1:       nd = 16'h0001 << $urandom_range(0, 15);
                    2:       nd = (16'h0001 << $urandom_range(0, 15)) |
                                  (16'h0001 << $urandom_range(0, 15));
                    default: nd = 16'($urandom);
                endcase
                hold = $urandom_range(1, 9);
            end
            hold--;
            D     = nd;
            rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (got !== mexp()) begin
                failures++;
                $display("FAIL random_model cyc=%0d D=%h got=%b exp=%b", e, nd, got, mexp());
            end
            checks++;
            if (prev_pulse && new_pulse) begin
                failures++;
                $display("FAIL random_double_pulse cyc=%0d got=11 exp=not both", e);
            end
            prev_pulse = new_pulse;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_multi();
        test_change();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
